audio_i2s_tx: RTL

AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

---
 rtl/audio_pkg.sv | 24 ++
 rtl/audio_sample_fifo.sv | 63 ++++++
 rtl/audio_i2s_tx.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the I2S audio transmit path: default widths, stereo sample layout, channel encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
`timescale 1ns/1ps
package audio_pkg;

    localparam int SAMPLE_W_DEF   = 16;
    localparam int FIFO_DEPTH_DEF = 4;

    localparam logic [15:0] UNDERRUN_CNT_MAX = 16'hFFFF;

    // One stereo frame as carried on the sample bus: left word in the upper half.
    typedef struct packed {
        logic [SAMPLE_W_DEF-1:0] left;
        logic [SAMPLE_W_DEF-1:0] right;
    } stereo_t;

    // Codec word-clock level: low selects the left channel.
    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous sample queue; head word is driven straight from the storage registers (first-word fall-through).
// Latency: a write is visible at o_rd_dat / o_level on the cycle after it is accepted.
// Backpressure: o_full blocks writes; reads while empty are ignored.
// Ports: clk, reset_n (async active-low), i_wr_vld/i_wr_dat write side, o_full,
//        i_rd_en/o_rd_dat/o_empty read side, o_level number of queued entries.
`timescale 1ns/1ps
module audio_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_wr_vld,
    input  logic [W-1:0]               i_wr_dat,
    output logic                       o_full,
    input  logic                       i_rd_en,
    output logic [W-1:0]               o_rd_dat,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [AW:0]   w_level;
    logic          w_wr;
    logic          w_rd;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_level = r_wr_ptr - r_rd_ptr;
    assign o_full  = (w_level == FULL_LVL);
    assign o_empty = (w_level == '0);
    assign o_level = w_level;
    assign w_wr    = i_wr_vld && !o_full;
    assign w_rd    = i_rd_en && !o_empty;

    assign o_rd_dat = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage is not reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_dat;
        end
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: queues stereo samples and shifts them MSB-first to a codec that masters bclk/daclrck.
// Latency: dacdat changes 1 clk after a synchronised bclk falling edge; MSB leaves one bclk after the word load.
// Backpressure: snk_ready = !full; an empty queue at a left load sends a zero frame and sets underrun.
// Ports: clk, reset_n (async active-low), snk_data/snk_valid/snk_ready sample input,
//        bclk/daclrck codec clocks (asynchronous), dacdat serial out, underrun/underrun_clr sticky flag,
//        fifo_level queue occupancy; underrun_count only when AUDIO_I2S_TX_UNDERRUN_CNT_EN is defined.
`timescale 1ns/1ps
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int SAMPLE_W   = SAMPLE_W_DEF
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [2*SAMPLE_W-1:0]         snk_data,
    input  logic                          snk_valid,
    output logic                          snk_ready,
    input  logic                          bclk,
    input  logic                          daclrck,
    output logic                          dacdat,
    output logic                          underrun,
    input  logic                          underrun_clr,
`ifdef AUDIO_I2S_TX_UNDERRUN_CNT_EN
    output logic [15:0]                   underrun_count,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    // ---------------- codec clock synchronisers and edge detect ----------------
    logic r_bclk_meta, r_bclk_s, r_bclk_d;
    logic r_lrck_meta, r_lrck_s;
    logic w_bclk_rise, w_bclk_fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bclk_meta <= 1'b0;
            r_bclk_s    <= 1'b0;
            r_bclk_d    <= 1'b0;
            r_lrck_meta <= 1'b0;
            r_lrck_s    <= 1'b0;
        end else begin
            r_bclk_meta <= bclk;
            r_bclk_s    <= r_bclk_meta;
            r_bclk_d    <= r_bclk_s;
            r_lrck_meta <= daclrck;
            r_lrck_s    <= r_lrck_meta;
        end
    end

    assign w_bclk_rise = r_bclk_s && !r_bclk_d;
    assign w_bclk_fall = !r_bclk_s && r_bclk_d;

    // ---------------- word-clock tracking ----------------
    // r_lrck_smp: level captured on the last bclk rise.
    // r_lrck_prev: level that was in force at the previous fall event. Both reset to
    // LEFT so that a reset taken mid-left never loads until a full right slot passes,
    // and a reset taken mid-right only reloads the (zeroed) right-hold register.
    chan_e r_lrck_smp;
    chan_e r_lrck_prev;
    logic  w_load, w_left_load, w_right_load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lrck_smp  <= CH_LEFT;
            r_lrck_prev <= CH_LEFT;
        end else begin
            if (w_bclk_rise) begin
                r_lrck_smp <= chan_e'(r_lrck_s);
            end
            if (w_bclk_fall) begin
                r_lrck_prev <= r_lrck_smp;
            end
        end
    end

    assign w_load       = w_bclk_fall && (r_lrck_smp != r_lrck_prev);
    assign w_left_load  = w_load && (r_lrck_smp == CH_LEFT);
    assign w_right_load = w_load && (r_lrck_smp == CH_RIGHT);

    // ---------------- sample queue ----------------
    logic                  r_ready_en;
    logic                  w_full, w_empty, w_pop;
    logic [2*SAMPLE_W-1:0] w_head;
    logic                  w_underrun_evt;

    audio_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (2*SAMPLE_W)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_wr_vld (snk_valid && snk_ready),
        .i_wr_dat (snk_data),
        .o_full   (w_full),
        .i_rd_en  (w_pop),
        .o_rd_dat (w_head),
        .o_empty  (w_empty),
        .o_level  (fifo_level)
    );

    // Keeps snk_ready low while reset is asserted even though the queue reads as empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
        end
    end

    assign snk_ready      = r_ready_en && !w_full;
    assign w_pop          = w_left_load && !w_empty;
    assign w_underrun_evt = w_left_load && w_empty;

    // ---------------- shifter ----------------
    // At every fall event the pending MSB goes out; a load replaces the register so the
    // first bit of the new word appears on the following fall (one-bit I2S delay).
    // Zeros shift in behind the LSB, padding long slots; short slots lose their LSBs.
    logic [SAMPLE_W-1:0] r_shift;
    logic [SAMPLE_W-1:0] r_right_hold;
    logic                r_dacdat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift      <= '0;
            r_right_hold <= '0;
            r_dacdat     <= 1'b0;
        end else if (w_bclk_fall) begin
            r_dacdat <= r_shift[SAMPLE_W-1];
            if (w_left_load) begin
                // The whole pair is taken at once so left and right never come from different samples.
                if (w_empty) begin
                    r_shift      <= '0;
                    r_right_hold <= '0;
                end else begin
                    r_shift      <= w_head[2*SAMPLE_W-1:SAMPLE_W];
                    r_right_hold <= w_head[SAMPLE_W-1:0];
                end
            end else if (w_right_load) begin
                r_shift <= r_right_hold;
            end else begin
                r_shift <= {r_shift[SAMPLE_W-2:0], 1'b0};
            end
        end
    end

    assign dacdat = r_dacdat;

    // ---------------- underrun reporting ----------------
    logic r_underrun;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_underrun <= 1'b0;
        end else if (w_underrun_evt) begin
            r_underrun <= 1'b1;
        end else if (underrun_clr) begin
            r_underrun <= 1'b0;
        end
    end

    assign underrun = r_underrun;

`ifdef AUDIO_I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_cnt;

    // Only conditional assignments: the count holds whenever nothing happens.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_underrun_cnt <= '0;
        end else if (w_underrun_evt) begin
            if (r_underrun_cnt != UNDERRUN_CNT_MAX) begin
                r_underrun_cnt <= r_underrun_cnt + 16'd1;
            end
        end else if (underrun_clr) begin
            r_underrun_cnt <= '0;
        end
    end

    assign underrun_count = r_underrun_cnt;
`endif

endmodule
